regfile_alu: RTL and testbench

Parametrised register-file execution core: accepts one instruction at a time over a valid/ready handshake, executes it against an internal bank of NREGS general registers of WIDTH bits, and reports result, flags and completion. Single-cycle ops for load, add, sub and logic; multi-cycle sequenced shift-add multiply and bit-serial shift. Successor to the fixed 4×8-bit CPU datapath. Adds parametrised width/depth, a reset, handshaking, carry/error flags and a register readback port.

---
 rtl/regfile_alu.sv | 179 +++++++++++++++++
 tb/tb_regfile_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_alu.sv
// Register-file execution core: one instruction at a time over valid/ready,
// single-cycle LOAD/ADD/SUB/logic ops, sequenced shift-add MUL and bit-serial shifts.
module regfile_alu #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [$clog2(NREGS)-1:0] in_dst,
    input  logic [$clog2(NREGS)-1:0] in_src,
    input  logic [WIDTH-1:0]         in_imm,
    input  logic                     in_use_imm,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     zf,
    output logic                     sf,
    output logic                     cf,
    output logic                     err,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_SHIFT, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] regs [NREGS];
    logic [3:0]       op_q;
    logic [RW-1:0]    dst_q;
    logic [RW-1:0]    dst_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;   // result, or low product half during MUL
    logic [WIDTH-1:0] hi_q;
    logic             cf_q;
    logic             sh_over_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   mul_sum;
    logic [CW-1:0]    sh_cnt_init;

    assign in_ready = (state_q == S_IDLE);
    assign rd_data  = regs[rd_addr];
    assign dst_nxt  = dst_q + RW'(1);

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latches.
    always_comb begin
        add_sum     = {1'b0, a_q} + {1'b0, b_q};
        mul_sum     = {1'b0, hi_q} + (res_q[0] ? {1'b0, b_q} : '0);
        sh_cnt_init = CW'(WIDTH);
        if (b_q == '0)
            sh_cnt_init = CW'(1);
        else if (b_q < W_VAL)
            sh_cnt_init = b_q[CW-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            hi_q      <= '0;
            cf_q      <= 1'b0;
            sh_over_q <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            zf        <= 1'b0;
            sf        <= 1'b0;
            cf        <= 1'b0;
            err       <= 1'b0;
            // NOTE: the register bank is architecturally visible after reset, so it is cleared here.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q      <= in_op;
                        dst_q     <= in_dst;
                        a_q       <= regs[in_dst];
                        b_q       <= in_use_imm ? in_imm : regs[in_src];
                        sh_over_q <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_DONE;
                    cf_q    <= 1'b0;
                    case (op_q)
                        OP_LOAD: res_q <= b_q;
                        OP_ADD:  {cf_q, res_q} <= add_sum;
                        OP_SUB: begin
                            res_q <= a_q - b_q;
                            cf_q  <= (a_q < b_q);
                        end
                        OP_AND:  res_q <= a_q & b_q;
                        OP_OR:   res_q <= a_q | b_q;
                        OP_XOR:  res_q <= a_q ^ b_q;
                        OP_MUL: begin
                            res_q   <= a_q;
                            hi_q    <= '0;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= S_MUL;
                        end
                        OP_SHR, OP_SHL: begin
                            res_q     <= a_q;
                            cnt_q     <= sh_cnt_init;
                            sh_over_q <= (b_q > W_VAL);
                            state_q   <= S_SHIFT;
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    // Multiplier bits leave res_q from the bottom as product bits enter from the top.
                    {hi_q, res_q} <= {mul_sum, res_q[WIDTH-1:1]};
                    cnt_q         <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= S_DONE;
                end
                S_SHIFT: begin
                    if (b_q != '0) begin
                        if (op_q == OP_SHL) {cf_q, res_q} <= {res_q, 1'b0};
                        else                {res_q, cf_q} <= {1'b0, res_q};
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    out_valid <= 1'b1;
                    if (op_q > OP_XOR) begin
                        err <= 1'b1;
                    end else if (op_q == OP_NOP) begin
                        err <= 1'b0;
                    end else if (op_q == OP_MUL) begin
                        regs[dst_q]   <= res_q;
                        regs[dst_nxt] <= hi_q;
                        out_data      <= res_q;
                        zf            <= (hi_q == '0) && (res_q == '0);
                        sf            <= hi_q[WIDTH-1];
                        cf            <= (hi_q != '0);
                        err           <= 1'b0;
                    end else begin
                        regs[dst_q] <= res_q;
                        out_data    <= res_q;
                        zf          <= (res_q == '0);
                        sf          <= res_q[WIDTH-1];
                        cf          <= cf_q & ~sh_over_q;
                        err         <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_alu.sv
// Directed bench for regfile_alu: expected completions are queued at issue and
// compared when out_valid pulses.
module tb_regfile_alu;

    localparam int WIDTH = 8;
    localparam int NREGS = 4;
    localparam int RW    = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [RW-1:0]    in_dst;
    logic [RW-1:0]    in_src;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             zf, sf, cf, err;
    logic [RW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    regfile_alu #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src(in_src), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .out_valid(out_valid), .out_data(out_data),
        .zf(zf), .sf(sf), .cf(cf), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;   // {zf, sf, cf, err}
        int               lat;
        logic [WIDTH-1:0] reg_val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [RW-1:0] dst,
                       input logic [RW-1:0] src, input logic [WIDTH-1:0] imm, input logic use_imm,
                       input logic [WIDTH-1:0] e_data, input logic [3:0] e_flags,
                       input int e_lat, input logic [WIDTH-1:0] e_reg);
        exp_t e;
        int   lat;
        logic busy_ok;
        logic got;
        e.data = e_data; e.flags = e_flags; e.lat = e_lat; e.reg_val = e_reg;
        sb.push_back(e);
        @(negedge clk);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_dst = dst; in_src = src;
        in_imm = imm; in_use_imm = use_imm; rd_addr = dst;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; busy_ok = 1'b1; got = 1'b0;
        do begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
        end while (lat < 200);
        e = sb.pop_front();
        check({tag, ".done"},  32'(got), 32'd1);
        check({tag, ".lat"},   32'(lat), 32'(e.lat));
        check({tag, ".busy"},  32'(busy_ok), 32'd1);
        check({tag, ".data"},  32'(out_data), 32'(e.data));
        check({tag, ".flags"}, 32'({zf, sf, cf, err}), 32'(e.flags));
        check({tag, ".rd"},    32'(rd_data), 32'(e.reg_val));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_regs(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                              input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
        logic [WIDTH-1:0] exp_r [NREGS];
        exp_r[0] = e0; exp_r[1] = e1; exp_r[2] = e2; exp_r[3] = e3;
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = RW'(i);
            #1 check($sformatf("%s.r%0d", tag, i), 32'(rd_data), 32'(exp_r[i]));
        end
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_dst = '0; in_src = '0;
        in_imm = '0; in_use_imm = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data), 32'd0);
        check("rst.flags",     32'({zf, sf, cf, err}), 32'd0);
        check("rst.ready",     32'(in_ready), 32'd1);
        check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);

        // args: tag op dst src imm use_imm | data {zf,sf,cf,err} latency reg[dst]
        run("load_r0",  4'd1,  2'd0, 2'd0, 8'h7F, 1'b1, 8'h7F, 4'b0000, 2,  8'h7F);
        run("add_r0",   4'd2,  2'd0, 2'd0, 8'h01, 1'b1, 8'h80, 4'b0100, 2,  8'h80);
        run("load_r1",  4'd1,  2'd1, 2'd0, 8'h05, 1'b1, 8'h05, 4'b0000, 2,  8'h05);
        run("sub_imm",  4'd3,  2'd1, 2'd0, 8'h06, 1'b1, 8'hFF, 4'b0110, 2,  8'hFF);
        run("sub_self", 4'd3,  2'd1, 2'd1, 8'h00, 1'b0, 8'h00, 4'b1000, 2,  8'h00);
        run("load_r3",  4'd1,  2'd3, 2'd0, 8'hFF, 1'b1, 8'hFF, 4'b0100, 2,  8'hFF);
        run("mul_wrap", 4'd4,  2'd3, 2'd0, 8'hFF, 1'b1, 8'h01, 4'b0110, 10, 8'h01);
        check_regs("mul", 8'hFE, 8'h00, 8'h00, 8'h01);
        run("load_r2",  4'd1,  2'd2, 2'd0, 8'h81, 1'b1, 8'h81, 4'b0100, 2,  8'h81);
        run("shl1",     4'd6,  2'd2, 2'd0, 8'h01, 1'b1, 8'h02, 4'b0010, 3,  8'h02);
        run("illegal",  4'hE,  2'd2, 2'd0, 8'h55, 1'b1, 8'h02, 4'b0011, 2,  8'h02);
        run("add_clr",  4'd2,  2'd2, 2'd0, 8'h01, 1'b1, 8'h03, 4'b0000, 2,  8'h03);
        run("nop",      4'd0,  2'd2, 2'd0, 8'h77, 1'b1, 8'h03, 4'b0000, 2,  8'h03);
        run("shr9",     4'd5,  2'd2, 2'd0, 8'h09, 1'b1, 8'h00, 4'b1000, 10, 8'h00);
        run("shr0",     4'd5,  2'd2, 2'd0, 8'h00, 1'b1, 8'h00, 4'b1000, 3,  8'h00);
        run("load_r1b", 4'd1,  2'd1, 2'd0, 8'h01, 1'b1, 8'h01, 4'b0000, 2,  8'h01);
        run("shl8",     4'd6,  2'd1, 2'd0, 8'h08, 1'b1, 8'h00, 4'b1010, 10, 8'h00);
        check_regs("pre_abort", 8'hFE, 8'h00, 8'h00, 8'h01);

        // Start a MUL, hold a competing LOAD on in_valid while busy, then reset mid-operation.
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd4; in_dst = 2'd3; in_imm = 8'h02; in_use_imm = 1'b1;
        @(posedge clk);
        #1 in_op = 4'd1; in_dst = 2'd1; in_imm = 8'hAA;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid === 1'b1 || in_ready !== 1'b0) seen = 1'b1;
        end
        check("abort.busy_hold", 32'(seen), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.ready",     32'(in_ready), 32'd1);
        check("abort.flags",     32'({zf, sf, cf, err}), 32'd0);
        check_regs("abort", 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort.no_pulse", 32'(seen), 32'd0);
        check("abort.ready2",   32'(in_ready), 32'd1);
        check_regs("post_abort", 8'h00, 8'h00, 8'h00, 8'h00);
        run("add_after", 4'd2, 2'd0, 2'd0, 8'hFF, 1'b1, 8'hFF, 4'b0100, 2, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
